// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types for the N-core snooping coherence bus:
// RAM handshake states, bus FSM states and counter sizing.
package coherence_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        WB     = 3'd2,
        SNOOP  = 3'd3,
        C2C    = 3'd4,
        MEMRD  = 3'd5
    } bus_state_t;

    // Word counter width; a one-word block still keeps a 1-bit counter.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_arbiter.sv
// Round-robin picker: req_i vector + ptr_i -> one-hot gnt_o and idx_o.
// Search starts at ptr_i+1 and wraps, so ptr_i itself is checked last.
module coherence_bus_arbiter_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] k;

    always_comb begin
        k     = '0;
        idx_o = '0;
        gnt_o = '0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int i = N; i >= 1; i--) begin
            k = IW'((int'(ptr_i) + i) % N);
            if (req_i[k]) begin
                idx_o = k;
            end
        end
        if (|req_i) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// N-core MSI snooping bus: arbitrates icache/dcache traffic onto one RAM port.
// Ports: per-core i*/d*/cc* cache buses, ram* memory controller port.
module coherence_bus_arbiter
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int NCPUS       = 2,
    parameter int BLOCK_WORDS = 2,
    parameter int WORD_W      = 32
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic [NCPUS-1:0]               iREN,
    input  logic [NCPUS-1:0][WORD_W-1:0]   iaddr,
    output logic [NCPUS-1:0]               iwait,
    output logic [NCPUS-1:0][WORD_W-1:0]   iload,
    input  logic [NCPUS-1:0]               dREN,
    input  logic [NCPUS-1:0]               dWEN,
    input  logic [NCPUS-1:0][WORD_W-1:0]   daddr,
    input  logic [NCPUS-1:0][WORD_W-1:0]   dstore,
    output logic [NCPUS-1:0]               dwait,
    output logic [NCPUS-1:0][WORD_W-1:0]   dload,
    input  logic [NCPUS-1:0]               cctrans,
    input  logic [NCPUS-1:0]               ccwrite,
    output logic [NCPUS-1:0]               ccwait,
    output logic [NCPUS-1:0]               ccinv,
    output logic [NCPUS-1:0][WORD_W-1:0]   ccsnoopaddr,
    input  ramstate_t                      ramstate,
    input  logic [WORD_W-1:0]              ramload,
    output logic                           ramREN,
    output logic                           ramWEN,
    output logic [WORD_W-1:0]              ramaddr,
    output logic [WORD_W-1:0]              ramstore
);

    localparam int IW = $clog2(NCPUS);
    localparam int CW = cnt_width(BLOCK_WORDS);

    typedef logic [IW-1:0] core_idx_t;

    bus_state_t       state_q, state_d;
    core_idx_t        rr_q, rr_d;
    core_idx_t        gnt_q, gnt_d;
    core_idx_t        src_q, src_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NCPUS-1:0] dreq;
    logic [NCPUS-1:0] d_gnt, i_gnt;
    core_idx_t        d_idx, i_idx;
    logic [NCPUS-1:0] rmask;
    logic [NCPUS-1:0] dirty;
    logic             all_resp;
    core_idx_t        src_pick;
    logic             acc;
    logic             last;

    // Coherent read misses and plain writebacks share the data class.
    assign dreq = (dREN & cctrans) | (dWEN & ~cctrans);

    coherence_bus_arbiter_rr_arbiter #(
        .N  (NCPUS),
        .IW (IW)
    ) u_darb (
        .req_i (dreq),
        .ptr_i (rr_q),
        .gnt_o (d_gnt),
        .idx_o (d_idx)
    );

    coherence_bus_arbiter_rr_arbiter #(
        .N  (NCPUS),
        .IW (IW)
    ) u_iarb (
        .req_i (iREN),
        .ptr_i (rr_q),
        .gnt_o (i_gnt),
        .idx_o (i_idx)
    );

    assign acc      = (ramstate == ACCESS);
    assign last     = (cnt_q == CW'(BLOCK_WORDS - 1));
    assign rmask    = NCPUS'(1) << gnt_q;
    // Requester counts as responded so only snoopees gate progress.
    assign all_resp = &(cctrans | rmask);
    assign dirty    = ccwrite & ~rmask;

    // Lowest dirty responder supplies, even if several claim ownership.
    always_comb begin
        src_pick = '0;
        for (int k = NCPUS - 1; k >= 0; k--) begin
            if (dirty[k]) begin
                src_pick = core_idx_t'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|d_gnt) begin
                    gnt_d = d_idx;
                    rr_d  = d_idx;
                    if (|(d_gnt & dREN & cctrans)) begin
                        state_d = SNOOP;
                    end else begin
                        state_d = WB;
                    end
                end else if (|i_gnt) begin
                    gnt_d   = i_idx;
                    rr_d    = i_idx;
                    state_d = IFETCH;
                end
            end
            IFETCH: begin
                if (acc) begin
                    state_d = IDLE;
                end
            end
            SNOOP: begin
                if (all_resp) begin
                    if (|dirty) begin
                        src_d   = src_pick;
                        state_d = C2C;
                    end else begin
                        state_d = MEMRD;
                    end
                end
            end
            WB, C2C, MEMRD: begin
                if (acc) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs follow the current state; ACCESS only opens the wait lines.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        unique case (state_q)
            IDLE: begin
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[gnt_q];
                if (acc) begin
                    iwait[gnt_q] = 1'b0;
                    iload[gnt_q] = ramload;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[gnt_q];
                ramstore = dstore[gnt_q];
                if (acc) begin
                    dwait[gnt_q] = 1'b0;
                end
            end
            SNOOP: begin
                for (int k = 0; k < NCPUS; k++) begin
                    if (k != int'(gnt_q)) begin
                        ccwait[k]      = 1'b1;
                        ccsnoopaddr[k] = daddr[gnt_q];
                        ccinv[k]       = ccwrite[gnt_q];
                    end
                end
            end
            C2C: begin
                // Owner's data goes to the requester and RAM together.
                ramWEN        = 1'b1;
                ramaddr       = daddr[src_q];
                ramstore      = dstore[src_q];
                ccwait[src_q] = 1'b1;
                dload[gnt_q]  = dstore[src_q];
                if (acc) begin
                    dwait[gnt_q] = 1'b0;
                    dwait[src_q] = 1'b0;
                end
            end
            MEMRD: begin
                ramREN  = 1'b1;
                ramaddr = daddr[gnt_q];
                if (acc) begin
                    dwait[gnt_q] = 1'b0;
                    dload[gnt_q] = ramload;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
